// File: rtl/snn_pkg.sv
// Shared defaults and encoder state type for the SNN address-event fabric.
package snn_pkg;

  localparam int unsigned SNN_N_NEURONS = 16;
  localparam int unsigned SNN_ADDR_W    = 4;
  localparam int unsigned SNN_MIN_GAP   = 18;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } enc_state_t;

endpackage

// File: rtl/spike_priority_encoder.sv
// Combinational lowest-index-first priority encoder over a spike/pending vector.
module spike_priority_encoder
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS = SNN_N_NEURONS,
  parameter int unsigned ADDR_W    = SNN_ADDR_W
) (
  input  logic [N_NEURONS-1:0] vec,
  output logic [ADDR_W-1:0]    idx,
  output logic                 any
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ADDR_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_event_encoder.sv
// Address-event transmitter: serialises a captured spike vector into lowest-index-first events.
// Define EVENT_PACING_EN to add a MIN_GAP idle gap after every accepted event.
module spike_event_encoder
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS = SNN_N_NEURONS,
  parameter int unsigned ADDR_W    = SNN_ADDR_W,
  parameter int unsigned MIN_GAP   = SNN_MIN_GAP
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 spike_done,
  input  logic [N_NEURONS-1:0] spike,
  input  logic                 event_ready,
  output logic                 event_valid,
  output logic [ADDR_W-1:0]    event_addr,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  enc_state_t           state;
  logic [N_NEURONS-1:0] pending;
  logic [N_NEURONS-1:0] pending_next;
  logic [N_NEURONS-1:0] acc_mask;
  logic                 acc;
  logic                 collide;
  logic [ADDR_W-1:0]    next_idx;
  logic                 next_any;

`ifdef EVENT_PACING_EN
  localparam logic [7:0] GapLoad = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;
  logic [7:0] gap_cnt;
`else
  logic [7:0] unused_min_gap;
  assign unused_min_gap = 8'(MIN_GAP);
`endif

  assign acc = event_valid & event_ready;

  always_comb begin
    acc_mask = '0;
    if (acc) acc_mask[event_addr] = 1'b1;
  end

  // Capture is OR-ed in after the accept-clear, so a re-fired index survives its own accept.
  assign pending_next = (pending & ~acc_mask) | (spike_done ? spike : '0);
  assign collide      = spike_done & (|(spike & pending & ~acc_mask));
  assign busy         = (state != IDLE) | (|pending);

  spike_priority_encoder #(
    .N_NEURONS(N_NEURONS),
    .ADDR_W   (ADDR_W)
  ) u_prio (
    .vec(pending_next),
    .idx(next_idx),
    .any(next_any)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pending_next;
      if (collide) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      event_valid <= 1'b0;
      event_addr  <= '0;
      frame_done  <= 1'b0;
`ifdef EVENT_PACING_EN
      gap_cnt     <= 8'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (next_any) begin
            state       <= SEND;
            event_valid <= 1'b1;
            event_addr  <= next_idx;
          end
        end
        SEND: begin
          if (acc) begin
            frame_done <= ~next_any;
`ifdef EVENT_PACING_EN
            if (MIN_GAP != 0) begin
              state       <= GAP;
              event_valid <= 1'b0;
              gap_cnt     <= GapLoad;
            end else
`endif
            if (next_any) begin
              event_addr <= next_idx;
            end else begin
              state       <= IDLE;
              event_valid <= 1'b0;
            end
          end
        end
        GAP: begin
`ifdef EVENT_PACING_EN
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (next_any) begin
            state       <= SEND;
            event_valid <= 1'b1;
            event_addr  <= next_idx;
          end else begin
            state <= IDLE;
          end
`else
          state       <= IDLE;
          event_valid <= 1'b0;
`endif
        end
        default: begin
          state       <= IDLE;
          event_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Self-checking bench for spike_event_encoder: directed scenarios plus a randomized model comparison.
module tb_spike_event_encoder;

  localparam int N    = 16;
  localparam int AW   = 4;
  localparam int GAPN = 18;
`ifdef EVENT_PACING_EN
  localparam int PACE = GAPN;
`else
  localparam int PACE = 0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          spike_done = 1'b0;
  logic [N-1:0]  spike = '0;
  logic          event_ready = 1'b0;
  logic          overflow_clr = 1'b0;
  logic          event_valid;
  logic [AW-1:0] event_addr;
  logic          busy;
  logic          frame_done;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int got[$];
  bit timed_out;

  spike_event_encoder #(
    .N_NEURONS(N),
    .ADDR_W   (AW),
    .MIN_GAP  (GAPN)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .spike_done  (spike_done),
    .spike       (spike),
    .event_ready (event_ready),
    .event_valid (event_valid),
    .event_addr  (event_addr),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [N-1:0] v);
    spike_done = 1'b1;
    spike      = v;
    tick();
    spike_done = 1'b0;
    spike      = '0;
  endtask

  // Gathers accepted addresses (event_ready held by caller) until the encoder goes idle.
  task automatic run_collect(input int bound);
    got.delete();
    timed_out = 1'b0;
    for (int n = 0; n < bound; n++) begin
      if (!busy) return;
      if (event_valid && event_ready) got.push_back(int'(event_addr));
      tick();
    end
    timed_out = busy;
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", event_valid); end
    checks++; if (event_addr !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", event_addr); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset_n = 1'b1;
    tick();
    checks++; if (event_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle valid %b busy %b want 0 0", event_valid, busy); end
  endtask

  task automatic test_sparse_frame();
    int exp_a[4] = '{0, 5, 10, 15};
    event_ready = 1'b1;
    strobe(16'h8421);
    for (int i = 0; i < 4; i++) begin
      checks++; if (event_valid !== 1'b1 || event_addr !== AW'(exp_a[i]) || frame_done !== 1'b0) begin
        errors++; $display("FAIL sparse_ev%0d valid %b addr %0d fd %b want 1 %0d 0",
                           i, event_valid, event_addr, frame_done, exp_a[i]); end
      tick();
    end
    checks++; if (event_valid !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL sparse_end valid %b fd %b busy %b want 0 1 0", event_valid, frame_done, busy); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL sparse_fd_pulse got %b want 0", frame_done); end
    event_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    event_ready = 1'b0;
    strobe(16'h0003);
    for (int i = 0; i < 5; i++) begin
      checks++; if (event_valid !== 1'b1 || event_addr !== 4'd0) begin
        errors++; $display("FAIL hold_c%0d valid %b addr %0d want 1 0", i, event_valid, event_addr); end
      if (i < 4) tick();
    end
    event_ready = 1'b1;
    tick();
    checks++; if (event_valid !== 1'b1 || event_addr !== 4'd1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL hold_second valid %b addr %0d fd %b want 1 1 0", event_valid, event_addr, frame_done); end
    tick();
    checks++; if (event_valid !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_end valid %b fd %b busy %b want 0 1 0", event_valid, frame_done, busy); end
    event_ready = 1'b0;
  endtask

  task automatic test_pacing();
    event_ready = 1'b1;
    strobe(16'h0006);
    checks++; if (event_valid !== 1'b1 || event_addr !== 4'd1) begin
      errors++; $display("FAIL pace_first valid %b addr %0d want 1 1", event_valid, event_addr); end
    tick();
    for (int i = 0; i < GAPN; i++) begin
      checks++; if (event_valid !== 1'b0 || frame_done !== 1'b0) begin
        errors++; $display("FAIL pace_gap%0d valid %b fd %b want 0 0", i, event_valid, frame_done); end
      tick();
    end
    checks++; if (event_valid !== 1'b1 || event_addr !== 4'd2) begin
      errors++; $display("FAIL pace_second valid %b addr %0d want 1 2", event_valid, event_addr); end
    tick();
    checks++; if (event_valid !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL pace_end valid %b fd %b busy %b want 0 1 1", event_valid, frame_done, busy); end
    run_collect(60);
    checks++; if (got.size() != 0 || timed_out) begin
      errors++; $display("FAIL pace_drain events %0d timeout %b want 0 0", got.size(), timed_out); end
    event_ready = 1'b0;
  endtask

  task automatic test_overflow();
    event_ready = 1'b0;
    strobe(16'h0100);
    checks++; if (event_valid !== 1'b1 || event_addr !== 4'd8 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_first valid %b addr %0d ovf %b want 1 8 0", event_valid, event_addr, overflow); end
    strobe(16'h0101);
    checks++; if (overflow !== 1'b1 || event_addr !== 4'd8) begin
      errors++; $display("FAIL ovf_set ovf %b addr %0d want 1 8", overflow, event_addr); end
    event_ready = 1'b1;
    run_collect(100);
    checks++; if (got.size() != 2 || got[0] != 8 || got[1] != 0 || timed_out) begin
      errors++; $display("FAIL ovf_order n %0d first %0d second %0d want 2 8 0", got.size(), got[0], got[1]); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
    event_ready = 1'b0;
  endtask

  task automatic test_recapture();
    event_ready = 1'b1;
    strobe(16'h0010);
    checks++; if (event_valid !== 1'b1 || event_addr !== 4'd4) begin
      errors++; $display("FAIL recap_first valid %b addr %0d want 1 4", event_valid, event_addr); end
    strobe(16'h0010);
    run_collect(100);
    checks++; if (got.size() != 1 || got[0] != 4 || timed_out) begin
      errors++; $display("FAIL recap_resend n %0d addr %0d want 1 4", got.size(), got[0]); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL recap_ovf got %b want 0", overflow); end
    event_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit seen;
    event_ready = 1'b0;
    strobe(16'hF000);
    checks++; if (event_valid !== 1'b1 || event_addr !== 4'd12 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre valid %b addr %0d busy %b want 1 12 1", event_valid, event_addr, busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (event_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_async valid %b busy %b want 0 0", event_valid, busy); end
    @(posedge clock);
    #3 reset_n = 1'b1;
    event_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (event_valid || frame_done || busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_after activity %b want 0", seen); end
    event_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] m_pend, keep, sp;
    bit m_valid, m_fd, m_ovf, acc, sd, rdy, clr, m_busy;
    int m_addr, m_gap, low;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_pend = '0; m_valid = 0; m_fd = 0; m_ovf = 0; m_addr = 0; m_gap = 0;
    for (int c = 0; c < 3000; c++) begin
      sd  = ($urandom % 5) == 0;
      sp  = N'($urandom & $urandom & $urandom);
      rdy = ($urandom % 3) != 0;
      clr = ($urandom % 20) == 0;
      spike_done = sd; spike = sp; event_ready = rdy; overflow_clr = clr;
      acc  = m_valid && rdy;
      keep = m_pend;
      if (acc) keep[m_addr] = 1'b0;
      if (sd && (sp & keep) != 0) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_pend = keep | (sd ? sp : '0);
      low = lowest(m_pend);
      m_fd = 0;
      if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0 && m_pend != 0) begin m_valid = 1; m_addr = low; end
      end else if (m_valid) begin
        if (acc) begin
          m_fd = (m_pend == 0);
          if (PACE > 0) begin m_valid = 0; m_gap = PACE; end
          else if (m_pend != 0) m_addr = low;
          else m_valid = 0;
        end
      end else if (m_pend != 0) begin
        m_valid = 1; m_addr = low;
      end
      m_busy = m_valid || m_gap > 0 || m_pend != 0;
      tick();
      checks++; if (event_valid !== m_valid) begin
        errors++; $display("FAIL rnd_valid c%0d got %b want %b", c, event_valid, m_valid); end
      if (m_valid) begin
        checks++; if (event_addr !== AW'(m_addr)) begin
          errors++; $display("FAIL rnd_addr c%0d got %0d want %0d", c, event_addr, m_addr); end
      end
      checks++; if (frame_done !== m_fd) begin
        errors++; $display("FAIL rnd_fd c%0d got %b want %b", c, frame_done, m_fd); end
      checks++; if (overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_ovf c%0d got %b want %b", c, overflow, m_ovf); end
      checks++; if (busy !== m_busy) begin
        errors++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy, m_busy); end
    end
    spike_done = 1'b0; spike = '0; event_ready = 1'b0; overflow_clr = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef EVENT_PACING_EN
    test_pacing();
`else
    test_sparse_frame();
    test_backpressure();
`endif
    test_overflow();
    test_recapture();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
